// File: rtl/bus_pair_arbiter.sv
// -----------------------------------------------------------------------------
// bus_pair_arbiter
//   Two-source valid/ready arbiter with a single output register.  It feeds a
//   4-bit 2:1 bus selector: out_sel tells the selector which source the held
//   word came from (0 = A, 1 = B).
//
//   Arbitration is round-robin (FIXED_PRI = 0) or A-always-wins (FIXED_PRI = 1).
//   A new word is loaded whenever the register is empty or being drained, so
//   sustained throughput is one word per cycle with no bubble on drain+refill.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   a_valid/a_data/a_ready  source A channel
//   b_valid/b_data/b_ready  source B channel
//   out_valid/out_data/out_sel/out_ready  registered output channel
//   cnt_a, cnt_b          saturating grant counters (BUS_PAIR_ARB_STATS_EN only)
//
// Optional feature
//   Define BUS_PAIR_ARB_STATS_EN to add the cnt_a / cnt_b ports and counters.
// -----------------------------------------------------------------------------
module bus_pair_arbiter #(
    parameter int WIDTH     = 4,
    parameter int FIXED_PRI = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
`ifdef BUS_PAIR_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_sel_q, out_sel_d;
    // Source of the most recent transfer (0 = A, 1 = B); resets to B so that
    // A takes the first tie.
    logic               last_grant_q, last_grant_d;

    logic               load_en;
    logic               grant_a;
    logic               grant_b;
    logic               xfer_a;
    logic               xfer_b;

    // ---------------------------------------------------------------- grant
    always_comb begin
        load_en = (state_q == EMPTY) | out_ready;
        // A wins if it is alone, if priority is fixed, or if B went last.
        grant_a = a_valid & (~b_valid | (FIXED_PRI != 0) | last_grant_q);
        grant_b = b_valid & ~grant_a;
        // Readies are held low while reset is asserted so nothing is accepted
        // into a register that is being cleared.
        a_ready = rst_n & load_en & grant_a;
        b_ready = rst_n & load_en & grant_b;
        xfer_a  = a_valid & a_ready;
        xfer_b  = b_valid & b_ready;
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            out_data_q   <= '0;
            out_sel_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ---------------------------------------------------- next-state logic
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        if (xfer_a) begin
            state_d      = FULL;
            out_data_d   = a_data;
            out_sel_d    = 1'b0;
            last_grant_d = 1'b0;
        end else if (xfer_b) begin
            state_d      = FULL;
            out_data_d   = b_data;
            out_sel_d    = 1'b1;
            last_grant_d = 1'b1;
        end else if (out_ready) begin
            // Drained with nothing to refill; data and sel keep last values.
            state_d = EMPTY;
        end
    end

    // -------------------------------------------------------- output logic
    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = out_data_q;
        out_sel   = out_sel_q;
    end

`ifdef BUS_PAIR_ARB_STATS_EN
    // --------------------------------------------- saturating grant counters
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (xfer_a && (cnt_a_q != {CNT_W{1'b1}})) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (xfer_b && (cnt_b_q != {CNT_W{1'b1}})) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule
